// File: rtl/ir_motor_ctrl_if.sv
// rtl/ir_motor_ctrl_if.sv - IR frame input bus and motor driver outputs of ir_motor_ctrl
interface ir_motor_ctrl_if;
  logic [31:0] Din;
  logic        MotA;
  logic        MotB;
  logic [2:0]  Level;
  logic        CmdValid;
  logic        Err;

  modport master (
    output Din,
    input  MotA, MotB, Level, CmdValid, Err
  );

  modport slave (
    input  Din,
    output MotA, MotB, Level, CmdValid, Err
  );
endinterface

// File: rtl/ir_motor_ctrl.sv
// rtl/ir_motor_ctrl.sv - NEC frame to H-bridge PWM motor controller with dead time
module ir_motor_ctrl #(
  parameter logic [7:0] ADDR        = 8'h00,
  parameter logic [7:0] KEY_FWD     = 8'h18,
  parameter logic [7:0] KEY_REV     = 8'h52,
  parameter logic [7:0] KEY_STOP    = 8'h1C,
  parameter logic [7:0] KEY_UP      = 8'h5A,
  parameter logic [7:0] KEY_DN      = 8'h08,
  parameter int         PWM_PERIOD  = 100,
  parameter int         DUTY_STEP   = 14,
  parameter int         DEAD_CYC    = 500,
  parameter int         TIMEOUT_CYC = 100000
) (
  input  logic             CLK10kHz,
  input  logic             RST,
  ir_motor_ctrl_if.slave   bus
);

  localparam int CW = $clog2(PWM_PERIOD);
  localparam int DW = $clog2(DEAD_CYC);

  typedef enum logic [1:0] {
    ST_STOP   = 2'd0,
    ST_FWD    = 2'd1,
    ST_REV    = 2'd2,
    ST_SWITCH = 2'd3
  } state_t;

  state_t          state_q, state_d;
  state_t          tgt_q, tgt_d;
  logic [31:0]     din_r_q, din_r_d;
  logic            din_nz_q, din_nz_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   dead_q, dead_d;
  logic [2:0]      level_q, level_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic            err_q, err_d;
  logic            mot_a_q, mot_a_d;
  logic            mot_b_q, mot_b_d;
`ifdef IR_DEADMAN_EN
  logic [31:0]     dm_q, dm_d;
`endif

  logic [7:0]  f_addr, f_naddr, f_cmd, f_ncmd;
  logic        evt;
  logic        frame_ok;
  logic [31:0] duty;
  logic        pwm;

  assign f_addr   = din_r_q[7:0];
  assign f_naddr  = din_r_q[15:8];
  assign f_cmd    = din_r_q[23:16];
  assign f_ncmd   = din_r_q[31:24];
  assign evt      = (din_r_q != 32'd0) && !din_nz_q;
  assign frame_ok = (f_addr == ADDR) && (f_naddr == ~f_addr) && (f_ncmd == ~f_cmd);

  assign duty = {29'd0, level_q} * DUTY_STEP;
  assign pwm  = ({{(32-CW){1'b0}}, cnt_q} < duty);

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    dead_d      = dead_q;
    level_d     = level_q;
    cmd_valid_d = 1'b0;
    err_d       = 1'b0;
    din_r_d     = bus.Din;
    din_nz_d    = (din_r_q != 32'd0);
    cnt_d       = (cnt_q == CW'(PWM_PERIOD - 1)) ? '0 : cnt_q + CW'(1);

    if (evt) begin
      if (!frame_ok) begin
        err_d = 1'b1;
      end else begin
        case (f_cmd)
          KEY_FWD: begin
            cmd_valid_d = 1'b1;
            case (state_q)
              ST_STOP:   state_d = ST_FWD;
              ST_REV:    begin state_d = ST_SWITCH; tgt_d = ST_FWD; dead_d = '0; end
              ST_SWITCH: tgt_d = ST_FWD;
              default:   ;
            endcase
          end
          KEY_REV: begin
            cmd_valid_d = 1'b1;
            case (state_q)
              ST_STOP:   state_d = ST_REV;
              ST_FWD:    begin state_d = ST_SWITCH; tgt_d = ST_REV; dead_d = '0; end
              ST_SWITCH: tgt_d = ST_REV;
              default:   ;
            endcase
          end
          KEY_STOP: begin
            cmd_valid_d = 1'b1;
            state_d     = ST_STOP;
            dead_d      = '0;
          end
          KEY_UP: begin
            cmd_valid_d = 1'b1;
            if (level_q != 3'd7) level_d = level_q + 3'd1;
          end
          KEY_DN: begin
            cmd_valid_d = 1'b1;
            if (level_q != 3'd0) level_d = level_q - 3'd1;
          end
          default: ;
        endcase
      end
    end

    if (state_q == ST_SWITCH && state_d == ST_SWITCH) begin
      if (dead_q == DW'(DEAD_CYC - 1)) begin
        state_d = tgt_d;
        dead_d  = '0;
      end else begin
        dead_d = dead_q + DW'(1);
      end
    end

`ifdef IR_DEADMAN_EN
    if (cmd_valid_d) begin
      dm_d = 32'd0;
    end else if (dm_q != 32'(TIMEOUT_CYC)) begin
      dm_d = dm_q + 32'd1;
    end else begin
      dm_d = dm_q;
    end
    if (!cmd_valid_d && dm_q == 32'(TIMEOUT_CYC - 1) && state_q != ST_STOP) begin
      state_d = ST_STOP;
      dead_d  = '0;
    end
`endif

    mot_a_d = (state_q == ST_FWD) && pwm;
    mot_b_d = (state_q == ST_REV) && pwm;
  end

  always_ff @(posedge CLK10kHz or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_STOP;
      tgt_q       <= ST_FWD;
      din_r_q     <= '0;
      din_nz_q    <= 1'b0;
      cnt_q       <= '0;
      dead_q      <= '0;
      level_q     <= 3'd4;
      cmd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      mot_a_q     <= 1'b0;
      mot_b_q     <= 1'b0;
`ifdef IR_DEADMAN_EN
      dm_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      din_r_q     <= din_r_d;
      din_nz_q    <= din_nz_d;
      cnt_q       <= cnt_d;
      dead_q      <= dead_d;
      level_q     <= level_d;
      cmd_valid_q <= cmd_valid_d;
      err_q       <= err_d;
      mot_a_q     <= mot_a_d;
      mot_b_q     <= mot_b_d;
`ifdef IR_DEADMAN_EN
      dm_q        <= dm_d;
`endif
    end
  end

  assign bus.MotA     = mot_a_q;
  assign bus.MotB     = mot_b_q;
  assign bus.Level    = level_q;
  assign bus.CmdValid = cmd_valid_q;
  assign bus.Err      = err_q;

endmodule

// File: tb/tb_ir_motor_ctrl.sv
// tb/tb_ir_motor_ctrl.sv - scoreboard bench for ir_motor_ctrl
`timescale 1us/1ns
module tb_ir_motor_ctrl;

`ifdef IR_DEADMAN_EN
  localparam int TB_TIMEOUT_CYC = 1000;
`else
  localparam int TB_TIMEOUT_CYC = 100000;
`endif

  logic CLK10kHz = 1'b0;
  logic RST      = 1'b0;

  ir_motor_ctrl_if bus ();

  ir_motor_ctrl #(.TIMEOUT_CYC(TB_TIMEOUT_CYC)) dut (
    .CLK10kHz (CLK10kHz),
    .RST      (RST),
    .bus      (bus)
  );

  always #50 CLK10kHz = ~CLK10kHz;

  typedef struct packed {
    logic       is_err;
    logic [2:0] level;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [31:0] F_FWD   = 32'hE718FF00;
  localparam logic [31:0] F_REV   = 32'hAD52FF00;
  localparam logic [31:0] F_STOP  = 32'hE31CFF00;
  localparam logic [31:0] F_UP    = 32'hA55AFF00;
  localparam logic [31:0] F_DN    = 32'hF708FF00;
  localparam logic [31:0] F_BADC  = 32'hE719FF00;
  localparam logic [31:0] F_BADA  = 32'hE718FE00;
  localparam logic [31:0] F_ADDR1 = 32'hE718FE01;
  localparam logic [31:0] F_UNK   = 32'hFE01FF00;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK10kHz);
  endtask

  task automatic send(input logic [31:0] f);
    bus.Din = f;
    @(negedge CLK10kHz);
    @(negedge CLK10kHz);
    bus.Din = '0;
  endtask

  task automatic expect_cmd(input logic [2:0] lvl);
    exp_t e;
    e.is_err = 1'b0;
    e.level  = lvl;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input logic [2:0] lvl);
    exp_t e;
    e.is_err = 1'b1;
    e.level  = lvl;
    exp_q.push_back(e);
  endtask

  task automatic wait_evt(input string name);
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (bus.CmdValid || bus.Err) seen = 1;
      else @(negedge CLK10kHz);
    end
    check({name, "_pulse_seen"}, int'(seen), 1);
  endtask

  task automatic count_hi(input int n, output int a, output int b);
    a = 0;
    b = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK10kHz);
      if (bus.MotA) a++;
      if (bus.MotB) b++;
      if (bus.MotA && bus.MotB) check("mot_exclusive", 1, 0);
    end
  endtask

  always @(negedge CLK10kHz) begin : monitor
    exp_t e;
    if (RST && (bus.CmdValid || bus.Err)) begin
      if (exp_q.size() == 0) begin
        check("pulse_expected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("pulse_is_err", int'(bus.Err), int'(e.is_err));
        check("pulse_cmd_valid", int'(bus.CmdValid), int'(!e.is_err));
        check("pulse_level", int'(bus.Level), int'(e.level));
      end
    end
  end

  initial begin : watchdog
    #(100 * 20000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a, b;
    bus.Din = '0;
    idle(3);
    check("rst_mota", int'(bus.MotA), 0);
    check("rst_motb", int'(bus.MotB), 0);
    check("rst_level", int'(bus.Level), 4);
    check("rst_cmdvalid", int'(bus.CmdValid), 0);
    check("rst_err", int'(bus.Err), 0);
    RST = 1'b1;
    idle(3);

    expect_cmd(3'd4);
    send(F_FWD);
    wait_evt("fwd");
    idle(2);
    count_hi(100, a, b);
    check("fwd_l4_mota", a, 56);
    check("fwd_l4_motb", b, 0);

    expect_cmd(3'd4);
    send(F_REV);
    wait_evt("rev");
    count_hi(500, a, b);
    check("dead_mota", a, 0);
    check("dead_motb", b, 0);
    count_hi(100, a, b);
    check("rev_l4_mota", a, 0);
    check("rev_l4_motb", b, 56);

    for (int i = 0; i < 5; i++) begin
      expect_cmd((i < 3) ? 3'(5 + i) : 3'd7);
      send(F_UP);
      idle(3);
    end
    count_hi(100, a, b);
    check("rev_l7_motb", b, 98);
    check("level_sat_hi", int'(bus.Level), 7);

    for (int i = 0; i < 8; i++) begin
      expect_cmd((i < 7) ? 3'(6 - i) : 3'd0);
      send(F_DN);
      idle(3);
    end
    count_hi(100, a, b);
    check("l0_mota", a, 0);
    check("l0_motb", b, 0);
    check("level_sat_lo", int'(bus.Level), 0);

    expect_err(3'd0);
    send(F_BADC);
    idle(3);
    expect_err(3'd0);
    send(F_BADA);
    idle(3);
    expect_err(3'd0);
    send(F_ADDR1);
    idle(3);
    send(F_UNK);
    idle(3);

    for (int i = 0; i < 4; i++) begin
      expect_cmd(3'(1 + i));
      send(F_UP);
      idle(3);
    end
    count_hi(100, a, b);
    check("still_rev_motb", b, 56);

    expect_cmd(3'd4);
    send(F_FWD);
    idle(100);
    expect_cmd(3'd4);
    send(F_STOP);
    count_hi(700, a, b);
    check("switch_stop_mota", a, 0);
    check("switch_stop_motb", b, 0);

    expect_cmd(3'd5);
    send(F_UP);
    idle(3);
    expect_cmd(3'd5);
    send(F_FWD);
    idle(3);
    begin
      bit hi = 0;
      for (int i = 0; i < 200 && !hi; i++) begin
        @(negedge CLK10kHz);
        if (bus.MotA) hi = 1;
      end
      check("mota_went_high", int'(hi), 1);
    end
    RST = 1'b0;
    #1;
    check("async_rst_mota", int'(bus.MotA), 0);
    check("async_rst_level", int'(bus.Level), 4);
    idle(2);
    RST = 1'b1;
    idle(3);

`ifdef IR_DEADMAN_EN
    expect_cmd(3'd4);
    send(F_FWD);
    wait_evt("dm_fwd");
    idle(897);
    expect_cmd(3'd5);
    send(F_UP);
    wait_evt("dm_up");
    count_hi(200, a, b);
    check("dm_extended_mota", a, 140);
    idle(801);
    count_hi(100, a, b);
    check("dm_stopped_mota", a, 0);
    check("dm_level_kept", int'(bus.Level), 5);
`endif

    idle(5);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
